// File: rtl/blink_monitor.sv
// Receive-side blinker monitor: synchronizes a toggling input, measures half-periods
// between edges and declares lock. Optional glitch filter: BLINK_MONITOR_GLITCH_FILTER_EN.
module blink_monitor #(
    parameter int CNT_W    = 16,
    parameter int EXP_HALF = 8,
    parameter int TOL      = 1,
    parameter int LOCK_CNT = 4,
    parameter int TIMEOUT  = 64
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             iSig,
    output logic             oEdge,
    output logic [CNT_W-1:0] oHalfPeriod,
    output logic             oValid,
    output logic             oMatch,
    output logic             oLocked,
    output logic             oTimeout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]        CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]        TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [3:0]              LOCK_N   = 4'(LOCK_CNT);
    localparam logic signed [CNT_W:0]   EXP_S    = (CNT_W+1)'(EXP_HALF);
    localparam logic signed [CNT_W:0]   TOL_S    = (CNT_W+1)'(TOL);

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Extra sign bit keeps meas - EXP_HALF from wrapping for any counter value.
    function automatic logic inTol(input logic [CNT_W-1:0] meas);
        logic signed [CNT_W:0] diff;
        logic signed [CNT_W:0] mag;
        diff = signed'({1'b0, meas}) - EXP_S;
        mag  = (diff < 0) ? -diff : diff;
        return (mag <= TOL_S);
    endfunction

    state_t           state;
    state_t           nextState;
    logic             rSync1;
    logic             rSync2;
    logic             rPrev;
    logic             sigEdge;
    logic             prevNext;
    logic [CNT_W-1:0] rCnt;
    logic [3:0]       rMatch;

    logic [CNT_W-1:0] meas;
    logic             measOk;
    logic [CNT_W-1:0] nextCnt;
    logic [3:0]       nextMatchCnt;
    logic [CNT_W-1:0] nextHalf;
    logic             nextValid;
    logic             nextMatch;
    logic             nextLocked;
    logic             nextTimeout;

`ifdef BLINK_MONITOR_GLITCH_FILTER_EN
    logic rSync3;
    logic stable;

    // A level is accepted only after two identical samples; rPrev holds the accepted level.
    assign stable   = (rSync2 == rSync3);
    assign sigEdge  = stable && (rSync2 != rPrev);
    assign prevNext = stable ? rSync2 : rPrev;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            rSync3 <= 1'b0;
        end else begin
            rSync3 <= rSync2;
        end
    end
`else
    assign sigEdge  = rSync2 ^ rPrev;
    assign prevNext = rSync2;
`endif

    // Synchronizer and edge-detect stage
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            rSync1 <= 1'b0;
            rSync2 <= 1'b0;
            rPrev  <= 1'b0;
        end else begin
            rSync1 <= iSig;
            rSync2 <= rSync1;
            rPrev  <= prevNext;
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state       <= IDLE;
            rCnt        <= '0;
            rMatch      <= '0;
            oEdge       <= 1'b0;
            oHalfPeriod <= '0;
            oValid      <= 1'b0;
            oMatch      <= 1'b0;
            oLocked     <= 1'b0;
            oTimeout    <= 1'b0;
        end else begin
            state       <= nextState;
            rCnt        <= nextCnt;
            rMatch      <= nextMatchCnt;
            oEdge       <= sigEdge;
            oHalfPeriod <= nextHalf;
            oValid      <= nextValid;
            oMatch      <= nextMatch;
            oLocked     <= nextLocked;
            oTimeout    <= nextTimeout;
        end
    end

    always_comb begin
        nextState    = state;
        nextMatchCnt = rMatch;
        nextHalf     = oHalfPeriod;
        nextValid    = 1'b0;
        nextMatch    = oMatch;
        nextLocked   = oLocked;
        nextTimeout  = 1'b0;
        meas         = satInc(rCnt);
        measOk       = inTol(meas);
        nextCnt      = sigEdge ? '0 : satInc(rCnt);

        case (state)
            IDLE: begin
                if (sigEdge) begin
                    nextState    = ACQ;
                    nextMatchCnt = '0;
                end
            end
            ACQ, LOCKED: begin
                if (sigEdge) begin
                    nextHalf  = meas;
                    nextValid = 1'b1;
                    nextMatch = measOk;
                    if (!measOk) begin
                        nextState    = ACQ;
                        nextMatchCnt = '0;
                        nextLocked   = 1'b0;
                    end else if (state == ACQ) begin
                        if (rMatch + 4'd1 == LOCK_N) begin
                            nextState  = LOCKED;
                            nextLocked = 1'b1;
                        end
                        nextMatchCnt = rMatch + 4'd1;
                    end
                end else if (rCnt == TO_LAST) begin
                    // An edge in the same cycle takes priority, so timeout only fires here.
                    nextState    = IDLE;
                    nextTimeout  = 1'b1;
                    nextLocked   = 1'b0;
                    nextMatch    = 1'b0;
                    nextMatchCnt = '0;
                end
            end
            default: begin
                nextState    = IDLE;
                nextMatchCnt = '0;
                nextLocked   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_blink_monitor.sv
// Directed bench for blink_monitor: lock, relock, timeout, edge/timeout priority, glitch.
module tb_blink_monitor;

    logic        CLK = 1'b0;
    logic        RESETn;
    logic        iSig;
    logic        oEdge;
    logic [15:0] oHalfPeriod;
    logic        oValid;
    logic        oMatch;
    logic        oLocked;
    logic        oTimeout;

`ifdef BLINK_MONITOR_GLITCH_FILTER_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    int nAssert = 0;
    int nFail   = 0;

    int          nEdge, nValid, nTimeout, edgeIdx, toIdx, tickIdx;
    logic [15:0] lastHP;
    logic        lastMatch, lastLocked;

    blink_monitor #(
        .CNT_W(16), .EXP_HALF(8), .TOL(1), .LOCK_CNT(4), .TIMEOUT(64)
    ) dut (
        .CLK(CLK), .RESETn(RESETn), .iSig(iSig), .oEdge(oEdge),
        .oHalfPeriod(oHalfPeriod), .oValid(oValid), .oMatch(oMatch),
        .oLocked(oLocked), .oTimeout(oTimeout)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp)
        else begin
            nFail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clearCap();
        nEdge = 0; nValid = 0; nTimeout = 0; edgeIdx = 0; toIdx = 0; tickIdx = 0;
        lastHP = '0; lastMatch = 1'b0; lastLocked = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
            tickIdx++;
            if (oEdge) begin
                nEdge++;
                if (edgeIdx == 0) edgeIdx = tickIdx;
            end
            if (oValid) begin
                nValid++;
                lastHP     = oHalfPeriod;
                lastMatch  = oMatch;
                lastLocked = oLocked;
            end
            if (oTimeout) begin
                nTimeout++;
                toIdx = tickIdx;
            end
        end
    endtask

    // Toggle iSig, then observe n cycles; the oValid seen reports the previous spacing.
    task automatic step(input int n);
        clearCap();
        iSig = ~iSig;
        run(n);
    endtask

    initial begin
        RESETn = 1'b0;
        iSig   = 1'b0;
        clearCap();
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK);
            #1;
            iSig = ~iSig;
        end
        check("rst_edge", oEdge, 0);
        check("rst_valid", oValid, 0);
        check("rst_half", oHalfPeriod, 0);
        check("rst_match", oMatch, 0);
        check("rst_locked", oLocked, 0);
        check("rst_timeout", oTimeout, 0);

        RESETn = 1'b1;
        clearCap();
        run(6);
        check("quiet_edges", nEdge, 0);

        // Half-period 8: lock on the 5th edge
        step(8);
        check("first_edge_cnt", nEdge, 1);
        check("first_edge_lat", edgeIdx, LAT);
        check("first_edge_novalid", nValid, 0);
        step(8);
        check("hp8_valid", nValid, 1);
        check("hp8_half", lastHP, 8);
        check("hp8_match", lastMatch, 1);
        check("hp8_unlocked", lastLocked, 0);
        for (int k = 0; k < 2; k++) begin
            step(8);
            check("hp8_acq_locked", lastLocked, 0);
        end
        step(8);
        check("hp8_lock", lastLocked, 1);
        check("hp8_lock_half", lastHP, 8);
        step(8);
        check("hp8_stay", lastLocked, 1);

        // Single 12-cycle half-period breaks lock, then relock
        step(12);
        check("pre12_locked", lastLocked, 1);
        step(8);
        check("hp12_half", lastHP, 12);
        check("hp12_match", lastMatch, 0);
        check("hp12_unlock", lastLocked, 0);
        for (int k = 0; k < 3; k++) begin
            step(8);
            check("relock_half", lastHP, 8);
            check("relock_pending", lastLocked, 0);
        end
        step(8);
        check("relock", lastLocked, 1);

        // Hold iSig: timeout 64 cycles after the last counter clear
        clearCap();
        run(70);
        check("to_count", nTimeout, 1);
        check("to_index", toIdx, LAT + 56);
        check("to_noedge", nEdge, 0);
        check("to_locked", oLocked, 0);
        check("to_match", oMatch, 0);
        check("to_half_held", oHalfPeriod, 8);

        // Fresh acquisition at 10 (out of tolerance), then 9
        step(10);
        check("idle_edge", nEdge, 1);
        check("idle_novalid", nValid, 0);
        step(10);
        check("hp10_valid", nValid, 1);
        check("hp10_half", lastHP, 10);
        check("hp10_match", lastMatch, 0);
        step(10);
        check("hp10_nolock", lastLocked, 0);
        step(9);
        check("hp10_last", lastHP, 10);
        check("hp10_last_nolock", lastLocked, 0);
        for (int k = 0; k < 3; k++) begin
            step(9);
            check("hp9_half", lastHP, 9);
            check("hp9_match", lastMatch, 1);
            check("hp9_pending", lastLocked, 0);
        end
        step(9);
        check("hp9_lock", lastLocked, 1);

        // One-cycle glitch
        clearCap();
        iSig = ~iSig;
        run(1);
        iSig = ~iSig;
        run(10);
`ifdef BLINK_MONITOR_GLITCH_FILTER_EN
        check("glitch_edges", nEdge, 0);
        check("glitch_valid", nValid, 0);
        check("glitch_locked", oLocked, 1);
`else
        check("glitch_edges", nEdge, 2);
        check("glitch_valid", nValid, 2);
        check("glitch_half", lastHP, 1);
        check("glitch_unlock", lastLocked, 0);
`endif

        // Edge lands exactly on the timeout threshold: edge wins
        step(64);
`ifdef BLINK_MONITOR_GLITCH_FILTER_EN
        check("pre64_half", lastHP, 20);
`else
        check("pre64_half", lastHP, 10);
`endif
        check("pre64_noto", nTimeout, 0);
        step(8);
        check("hp64_noto", nTimeout, 0);
        check("hp64_valid", nValid, 1);
        check("hp64_half", lastHP, 64);
        check("hp64_match", lastMatch, 0);
        for (int k = 0; k < 3; k++) step(8);
        step(8);
        check("final_lock", lastLocked, 1);

        // Asynchronous reset while locked
        RESETn = 1'b0;
        #1;
        check("async_rst_locked", oLocked, 0);
        check("async_rst_half", oHalfPeriod, 0);
        check("async_rst_match", oMatch, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
